// File: rtl/pll_lock_sequencer_pkg.sv
// Shared PLL-domain types: sequencer state encoding and status counter widths.
// Imported by the sequencer, its interface and any other PLL-clocked block.
package pll_pkg;

   localparam int RETRY_W = 4;
   localparam int LOL_W   = 8;

   localparam logic [LOL_W-1:0] LOL_MAX = '1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESET_PLL = 3'd1,
      WAIT_LOCK = 3'd2,
      STABLE    = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } state_t;

   // Loss-of-lock counter sticks at all-ones instead of wrapping.
   function automatic logic [LOL_W-1:0] lol_sat_inc(input logic [LOL_W-1:0] v);
      return (v == LOL_MAX) ? v : v + LOL_W'(1);
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings.
// master = the sequencer; slave = the PLL wrapper / downstream stage.
interface pll_lock_sequencer_if;
   import pll_pkg::*;

   logic               en;
   logic               lock;
   logic               pllrst;
   logic               clken;
   logic               fail;
   logic [RETRY_W-1:0] retries;
   logic [LOL_W-1:0]   lol_cnt;
   state_t             state;

   modport master (
      input  en,
      input  lock,
      output pllrst,
      output clken,
      output fail,
      output retries,
      output lol_cnt,
      output state
   );

   modport slave (
      output en,
      output lock,
      input  pllrst,
      input  clken,
      input  fail,
      input  retries,
      input  lol_cnt,
      input  state
   );

endinterface

// File: rtl/pll_lock_sequencer_sync2.sv
// Generic 2-FF level synchronizer, synchronous active-high reset to 0.
// Output lags the input by two clk edges; no pulse stretching.
module sync2 #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pllrst, qualifies synchronized lock, gates clken, retries then fails.
// All outputs are registered decodes of the next state, so they move on the same edge as the state register.
module pll_lock_sequencer
   import pll_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 1000,
   parameter int STABLE_CYCLES = 64,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   pll_lock_sequencer_if.master bus
);

   logic               w_lock_s;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [RETRY_W-1:0] r_retries;
   logic [RETRY_W-1:0] w_retries_nxt;
   logic [LOL_W-1:0]   r_lol_cnt;
   logic [LOL_W-1:0]   w_lol_nxt;

   logic               r_pllrst;
   logic               r_clken;
   logic               r_fail;
   logic               w_pllrst_nxt;
   logic               w_clken_nxt;
   logic               w_fail_nxt;

   logic               w_rst_done;
   logic               w_timeout;
   logic               w_stable_done;
   logic               w_timed_state;

   sync2 #(.W(1)) u_lock_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (bus.lock),
      .o_q   (w_lock_s)
   );

   assign w_rst_done    = (r_cnt == CNT_W'(RST_CYCLES - 1));
   assign w_timeout     = (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));
   assign w_stable_done = (r_cnt == CNT_W'(STABLE_CYCLES - 1));

   always_comb begin
      w_state_nxt   = r_state;
      w_retries_nxt = r_retries;
      w_lol_nxt     = r_lol_cnt;

      // Dropping en aborts anything short of a latched failure.
      if (!bus.en && (r_state != FAIL)) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: w_state_nxt = RESET_PLL;
            RESET_PLL: begin
               if (w_rst_done) w_state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (w_lock_s) begin
                  w_state_nxt = STABLE;
               end else if (w_timeout) begin
                  w_retries_nxt = r_retries + RETRY_W'(1);
                  w_state_nxt   = (w_retries_nxt == RETRY_W'(MAX_RETRIES)) ? FAIL : RESET_PLL;
               end
            end
            STABLE: begin
               // A lock drop beats a coincident end of the qualification window.
               if (!w_lock_s) begin
                  w_state_nxt = WAIT_LOCK;
               end else if (w_stable_done) begin
                  w_state_nxt   = RUN;
                  w_retries_nxt = '0;
               end
            end
            RUN: begin
               if (!w_lock_s) begin
                  w_state_nxt = RESET_PLL;
                  w_lol_nxt   = lol_sat_inc(r_lol_cnt);
               end
            end
            FAIL:    w_state_nxt = FAIL;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_pllrst_nxt  = 1'b1;
      w_clken_nxt   = 1'b0;
      w_fail_nxt    = 1'b0;
      w_timed_state = 1'b0;
      case (w_state_nxt)
         IDLE:      w_pllrst_nxt = 1'b1;
         RESET_PLL: begin
            w_pllrst_nxt  = 1'b1;
            w_timed_state = 1'b1;
         end
         WAIT_LOCK: begin
            w_pllrst_nxt  = 1'b0;
            w_timed_state = 1'b1;
         end
         STABLE: begin
            w_pllrst_nxt  = 1'b0;
            w_timed_state = 1'b1;
         end
         RUN: begin
            w_pllrst_nxt = 1'b0;
            w_clken_nxt  = 1'b1;
         end
         FAIL:      w_fail_nxt = 1'b1;
         default:   w_pllrst_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_retries <= '0;
         r_lol_cnt <= '0;
         r_pllrst  <= 1'b1;
         r_clken   <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_retries <= w_retries_nxt;
         r_lol_cnt <= w_lol_nxt;
         r_pllrst  <= w_pllrst_nxt;
         r_clken   <= w_clken_nxt;
         r_fail    <= w_fail_nxt;
         // Interval counter restarts on every state change, runs only where it is compared.
         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if (w_timed_state) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.pllrst  = r_pllrst;
   assign bus.clken   = r_clken;
   assign bus.fail    = r_fail;
   assign bus.retries = r_retries;
   assign bus.lol_cnt = r_lol_cnt;
   assign bus.state   = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed/randomized bench for pll_lock_sequencer; expected timings come from cycle arithmetic on the
// parameters (2 sync stages + 1 decision edge) and expected counters from a small event tally.
module tb_pll_lock_sequencer;
   import pll_pkg::*;

   localparam int RST_C = 4;
   localparam int TO_C  = 20;
   localparam int STB_C = 8;
   localparam int MAXR  = 2;
   localparam int LAT   = 3;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   exp_lol  = 0;

   pll_lock_sequencer_if ifc ();

   pll_lock_sequencer #(
      .RST_CYCLES    (RST_C),
      .LOCK_TIMEOUT  (TO_C),
      .STABLE_CYCLES (STB_C),
      .MAX_RETRIES   (MAXR),
      .CNT_W         (16)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("no_clken_pllrst_overlap", {31'd0, ifc.clken & ifc.pllrst}, 0);
   endtask

   // In WAIT_LOCK: hold lock low d cycles, raise it, expect clken after sync + full stable window.
   task automatic qualify(input int d);
      int t;
      repeat (d) step();
      chk("wait_before_lock", ifc.state, WAIT_LOCK);
      ifc.lock = 1'b1;
      t = 0;
      while (ifc.clken !== 1'b1 && t < 80) begin
         step();
         t++;
      end
      chk("lock_to_clken", t, LAT + STB_C);
      chk("run_state", ifc.state, RUN);
      chk("run_retries", ifc.retries, 0);
   endtask

   // In RUN: drop lock for r cycles and time the fall, the reset pulse and the requalification.
   task automatic drop_lock(input int r);
      int t, hi, fall, exp_t;
      t = 0; hi = 0; fall = 0;
      ifc.lock = 1'b0;
      while (t < 80) begin
         step();
         t++;
         if (ifc.pllrst === 1'b1) hi++;
         if (ifc.clken === 1'b0 && fall == 0) fall = t;
         if (t == r) ifc.lock = 1'b1;
         if (ifc.clken === 1'b1 && fall != 0) break;
      end
      exp_lol++;
      exp_t = ((r + LAT > LAT + RST_C + 1) ? r + LAT : LAT + RST_C + 1) + STB_C;
      chk("drop_clken_fall", fall, LAT);
      chk("drop_pllrst_width", hi, RST_C);
      chk("drop_relock_time", t, exp_t);
      chk("drop_lol_cnt", ifc.lol_cnt, exp_lol);
   endtask

   // From RUN: lose lock into WAIT_LOCK, relock, then a 1-cycle low pulse g cycles after the rise.
   task automatic glitch(input int g);
      int t;
      ifc.lock = 1'b0;
      t = 0;
      while (ifc.state !== WAIT_LOCK && t < 60) begin
         step();
         t++;
      end
      exp_lol++;
      chk("lol_to_wait", t, LAT + RST_C);
      chk("glitch_lol_cnt", ifc.lol_cnt, exp_lol);
      ifc.lock = 1'b1;
      t = 0;
      while (ifc.clken !== 1'b1 && t < 80) begin
         step();
         t++;
         if (t == g) ifc.lock = 1'b0;
         if (t == g + 1) ifc.lock = 1'b1;
         if (t == g + LAT) chk("glitch_back_to_wait", ifc.state, WAIT_LOCK);
      end
      chk("glitch_to_run", t, g + LAT + 1 + STB_C);
   endtask

   initial begin
      int t, t_r1, w;
      rst      = 1'b1;
      ifc.en   = 1'b0;
      ifc.lock = 1'b0;
      step();
      step();
      chk("rst_state", ifc.state, IDLE);
      chk("rst_pllrst", ifc.pllrst, 1);
      chk("rst_clken", ifc.clken, 0);
      chk("rst_fail", ifc.fail, 0);
      chk("rst_retries", ifc.retries, 0);
      chk("rst_lol_cnt", ifc.lol_cnt, 0);
      rst = 1'b0;
      step();
      chk("idle_hold", ifc.state, IDLE);

      // Bring-up: exact reset pulse from IDLE, lock 6 cycles after release.
      ifc.en = 1'b1;
      for (int i = 0; i < RST_C; i++) begin
         step();
         chk("pulse_state", ifc.state, RESET_PLL);
         chk("pulse_pllrst", ifc.pllrst, 1);
      end
      step();
      chk("release_state", ifc.state, WAIT_LOCK);
      chk("release_pllrst", ifc.pllrst, 0);
      qualify(6);

      drop_lock(3);
      glitch(6);
      glitch(STB_C);

      // en drop in RUN.
      ifc.en = 1'b0;
      step();
      chk("en_off_run_state", ifc.state, IDLE);
      chk("en_off_run_outs", {ifc.pllrst, ifc.clken}, 2'b10);
      chk("en_off_run_retries", ifc.retries, 0);

      // One timeout, then en drop in WAIT_LOCK keeps retries; next timeout fails.
      ifc.lock = 1'b0;
      ifc.en   = 1'b1;
      t = 0;
      while (ifc.retries !== 4'd1 && t < 200) begin
         step();
         t++;
      end
      chk("first_timeout_time", t, 1 + RST_C + TO_C);
      chk("first_timeout_state", ifc.state, RESET_PLL);
      repeat (RST_C) step();
      chk("retry_wait_state", ifc.state, WAIT_LOCK);
      w = $urandom_range(1, TO_C - 5);
      repeat (w) step();
      ifc.en = 1'b0;
      step();
      chk("en_off_wait_state", ifc.state, IDLE);
      chk("en_off_wait_retries", ifc.retries, 1);
      chk("en_off_wait_outs", {ifc.pllrst, ifc.clken}, 2'b10);
      ifc.en = 1'b1;
      t = 0;
      while (ifc.fail !== 1'b1 && t < 200) begin
         step();
         t++;
      end
      chk("fail_time_after_kept_retry", t, 1 + RST_C + TO_C);
      chk("fail_retries", ifc.retries, MAXR);
      chk("fail_state", ifc.state, FAIL);
      chk("fail_outs", {ifc.pllrst, ifc.clken}, 2'b10);
      chk("fail_lol_cnt", ifc.lol_cnt, exp_lol);

      for (int i = 0; i < 20; i++) begin
         ifc.en   = 1'($urandom);
         ifc.lock = 1'($urandom);
         step();
         chk("fail_sticky", {ifc.state, ifc.fail, ifc.pllrst, ifc.clken}, {3'd5, 3'b110});
      end

      ifc.en   = 1'b0;
      ifc.lock = 1'b0;
      rst      = 1'b1;
      step();
      rst     = 1'b0;
      exp_lol = 0;
      chk("rst_from_fail_state", ifc.state, IDLE);
      chk("rst_from_fail_flags", {ifc.fail, ifc.pllrst, ifc.clken}, 3'b010);
      chk("rst_from_fail_lol", ifc.lol_cnt, 0);
      chk("rst_from_fail_retries", ifc.retries, 0);

      // Randomized bring-up and loss of lock.
      ifc.en = 1'b1;
      repeat (RST_C + 1) step();
      qualify($urandom_range(0, 12));
      drop_lock($urandom_range(1, 6));

      // Lock never comes: two full windows then FAIL.
      ifc.en = 1'b0;
      step();
      ifc.lock = 1'b0;
      ifc.en   = 1'b1;
      t = 0; t_r1 = 0;
      while (ifc.fail !== 1'b1 && t < 300) begin
         step();
         t++;
         if (ifc.retries === 4'd1 && t_r1 == 0) t_r1 = t;
      end
      chk("nolock_retry1_time", t_r1, 1 + RST_C + TO_C);
      chk("nolock_fail_time", t, 1 + MAXR * (RST_C + TO_C));
      chk("nolock_fail_state", ifc.state, FAIL);
      chk("nolock_fail_pllrst", ifc.pllrst, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
